// File: rtl/int_to_float_pipe.sv
// Three-stage integer to IEEE-754 binary32 converter: magnitude, normalise, round-to-nearest-even and pack.
// A single global stall freezes every stage while the output is held.
module int_to_float_pipe #(
    parameter int INT_W = 32,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [INT_W-1:0] in_data,
    input  logic             in_signed,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic             out_inexact,
    output logic [TAG_W-1:0] out_tag
);

    localparam int P_W = 7;

    logic             r_s1_valid;
    logic             r_s1_sign;
    logic [INT_W-1:0] r_s1_mag;
    logic [TAG_W-1:0] r_s1_tag;

    logic             r_s2_valid;
    logic             r_s2_sign;
    logic             r_s2_zero;
    logic [P_W-1:0]   r_s2_p;
    logic [INT_W-1:0] r_s2_norm;
    logic [TAG_W-1:0] r_s2_tag;

    logic             r_out_valid;
    logic [31:0]      r_out_data;
    logic             r_out_inexact;
    logic [TAG_W-1:0] r_out_tag;

    logic             w_stall;
    logic             w_s1_sign;
    logic [INT_W-1:0] w_s1_mag;
    logic [P_W-1:0]   w_p;
    logic [P_W-1:0]   w_shamt;
    logic [INT_W-1:0] w_norm;
    logic             w_zero;
    logic [23:0]      w_kept;
    logic             w_guard;
    logic             w_sticky;
    logic             w_round_up;
    logic [24:0]      w_sum;
    logic             w_carry;
    logic [22:0]      w_frac;
    logic [7:0]       w_exp;
    logic [31:0]      w_result;
    logic             w_inexact;

    assign w_stall  = r_out_valid & ~out_ready;
    assign in_ready = ~w_stall;

    // Two's-complement negate at full width: the most negative value maps onto 2^(INT_W-1).
    assign w_s1_sign = in_signed & in_data[INT_W-1];
    assign w_s1_mag  = w_s1_sign ? ((~in_data) + {{(INT_W-1){1'b0}}, 1'b1}) : in_data;

    always_comb begin
        w_p = '0;
        for (int i = 0; i < INT_W; i++) begin
            if (r_s1_mag[i]) begin
                w_p = P_W'(i);
            end
        end
    end

    assign w_shamt = P_W'(INT_W - 1) - w_p;
    assign w_norm  = r_s1_mag << w_shamt;
    assign w_zero  = ~|r_s1_mag;

    generate
        if (INT_W > 24) begin : g_round
            assign w_kept  = r_s2_norm[INT_W-1 -: 24];
            assign w_guard = r_s2_norm[INT_W-25];
            if (INT_W > 25) begin : g_sticky
                assign w_sticky = |r_s2_norm[INT_W-26:0];
            end else begin : g_no_sticky
                assign w_sticky = 1'b0;
            end
        end else begin : g_exact
            if (INT_W == 24) begin : g_full
                assign w_kept = r_s2_norm;
            end else begin : g_pad
                assign w_kept = {r_s2_norm, {(24-INT_W){1'b0}}};
            end
            assign w_guard  = 1'b0;
            assign w_sticky = 1'b0;
        end
    endgenerate

    // A carry out of the 24-bit mantissa leaves 1.000..., so only the exponent moves.
    assign w_round_up = w_guard & (w_sticky | w_kept[0]);
    assign w_sum      = {1'b0, w_kept} + {24'd0, w_round_up};
    assign w_carry    = w_sum[24];
    assign w_frac     = w_carry ? w_sum[23:1] : w_sum[22:0];
    assign w_exp      = 8'd127 + {1'b0, r_s2_p} + {7'd0, w_carry};
    assign w_result   = r_s2_zero ? 32'd0 : {r_s2_sign, w_exp, w_frac};
    assign w_inexact  = ~r_s2_zero & (w_guard | w_sticky);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid    <= 1'b0;
            r_s1_sign     <= 1'b0;
            r_s1_mag      <= '0;
            r_s1_tag      <= '0;
            r_s2_valid    <= 1'b0;
            r_s2_sign     <= 1'b0;
            r_s2_zero     <= 1'b0;
            r_s2_p        <= '0;
            r_s2_norm     <= '0;
            r_s2_tag      <= '0;
            r_out_valid   <= 1'b0;
            r_out_data    <= '0;
            r_out_inexact <= 1'b0;
            r_out_tag     <= '0;
        end else if (!w_stall) begin
            r_s1_valid    <= in_valid;
            r_s1_sign     <= w_s1_sign;
            r_s1_mag      <= w_s1_mag;
            r_s1_tag      <= in_tag;
            r_s2_valid    <= r_s1_valid;
            r_s2_sign     <= r_s1_sign;
            r_s2_zero     <= w_zero;
            r_s2_p        <= w_p;
            r_s2_norm     <= w_norm;
            r_s2_tag      <= r_s1_tag;
            r_out_valid   <= r_s2_valid;
            r_out_data    <= w_result;
            r_out_inexact <= w_inexact;
            r_out_tag     <= r_s2_tag;
        end
    end

    assign out_valid   = r_out_valid;
    assign out_data    = r_out_data;
    assign out_inexact = r_out_inexact;
    assign out_tag     = r_out_tag;

endmodule

// File: tb/tb_int_to_float_pipe.sv
// Randomised and directed bench for int_to_float_pipe: a 32-bit instance under a scoreboard
// fed by an arithmetic RNE reference model, plus an 8-bit instance for the exact-conversion path.
module tb_int_to_float_pipe;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_signed;
    logic [3:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_inexact;
    logic [3:0]  out_tag;

    logic        n_in_valid;
    logic        n_in_ready;
    logic [7:0]  n_in_data;
    logic        n_in_signed;
    logic [3:0]  n_in_tag;
    logic        n_out_valid;
    logic        n_out_ready;
    logic [31:0] n_out_data;
    logic        n_out_inexact;
    logic [3:0]  n_out_tag;

    int n_checks = 0;
    int n_errors = 0;

    int_to_float_pipe #(.INT_W(32), .TAG_W(4)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_signed(in_signed), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_inexact(out_inexact), .out_tag(out_tag)
    );

    int_to_float_pipe #(.INT_W(8), .TAG_W(4)) u_dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(n_in_valid), .in_ready(n_in_ready), .in_data(n_in_data),
        .in_signed(n_in_signed), .in_tag(n_in_tag),
        .out_valid(n_out_valid), .out_ready(n_out_ready), .out_data(n_out_data),
        .out_inexact(n_out_inexact), .out_tag(n_out_tag)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: exact integer arithmetic, rounding decided by comparing the discarded remainder with half an ulp.
    function automatic logic [32:0] ref_f32(input logic [63:0] val, input int w, input logic sgn);
        logic [63:0] v, mag, mant, rem, half;
        logic        neg, inexact;
        int          p, sh;
        v = val & ((64'd1 << w) - 64'd1);
        neg = sgn && v[w-1];
        mag = neg ? ((64'd1 << w) - v) : v;
        if (mag == 64'd0) return 33'd0;
        p = 0;
        for (int i = 0; i < 64; i++) if (mag[i]) p = i;
        inexact = 1'b0;
        if (p <= 23) begin
            mant = mag << (23 - p);
        end else begin
            sh   = p - 23;
            mant = mag >> sh;
            rem  = mag - (mant << sh);
            half = 64'd1 << (sh - 1);
            inexact = (rem != 64'd0);
            if (rem > half || (rem == half && mant[0])) mant = mant + 64'd1;
            if (mant == (64'd1 << 24)) begin
                mant = mant >> 1;
                p = p + 1;
            end
        end
        return {inexact, neg, 8'(p + 127), mant[22:0]};
    endfunction

    typedef struct packed {
        logic [31:0] data;
        logic        inexact;
        logic [3:0]  tag;
    } exp_t;

    exp_t        exp_q[$];
    logic [3:0]  rx_tags[$];

    // Scoreboard and protocol monitor for the 32-bit instance.
    initial begin : monitor
        logic        prev_stall;
        logic [31:0] prev_data;
        logic        prev_inx;
        logic [3:0]  prev_tag;
        logic [32:0] r;
        exp_t        e;
        prev_stall = 1'b0;
        prev_data  = '0;
        prev_inx   = 1'b0;
        prev_tag   = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_q.delete();
                prev_stall = 1'b0;
            end else begin
                check("in_ready_vs_stall", in_ready, !(out_valid && !out_ready));
                if (prev_stall) begin
                    check("hold_data", out_data, prev_data);
                    check("hold_inexact", out_inexact, prev_inx);
                    check("hold_tag", out_tag, prev_tag);
                end
                if (out_valid && out_ready) begin
                    check("expect_available", 64'(exp_q.size() != 0), 64'd1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check("sb_data", out_data, e.data);
                        check("sb_inexact", out_inexact, e.inexact);
                        check("sb_tag", out_tag, e.tag);
                    end
                    rx_tags.push_back(out_tag);
                    $display("out tag=%0d data=0x%08h inexact=%0d", out_tag, out_data, out_inexact);
                end
                if (in_valid && in_ready) begin
                    r = ref_f32({32'd0, in_data}, 32, in_signed);
                    exp_q.push_back({r[31:0], r[32], in_tag});
                end
                prev_stall = out_valid && !out_ready;
                prev_data  = out_data;
                prev_inx   = out_inexact;
                prev_tag   = out_tag;
            end
        end
    end

    task automatic send_check(input logic [31:0] d, input logic s, input logic [3:0] t,
                              input logic [31:0] exp_d, input logic exp_i, input string name);
        int lat;
        @(posedge clk); #1;
        in_valid = 1'b1; in_data = d; in_signed = s; in_tag = t;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        check({name, "_latency"}, 64'(lat), 64'd3);
        check({name, "_data"}, out_data, exp_d);
        check({name, "_inexact"}, out_inexact, exp_i);
        check({name, "_tag"}, out_tag, t);
    endtask

    task automatic send8(input logic [7:0] d, input logic s, input logic [3:0] t, input string name);
        int          lat;
        logic [32:0] r;
        r = ref_f32({56'd0, d}, 8, s);
        @(posedge clk); #1;
        n_in_valid = 1'b1; n_in_data = d; n_in_signed = s; n_in_tag = t;
        @(posedge clk); #1;
        n_in_valid = 1'b0;
        lat = 1;
        while (!n_out_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        check({name, "_latency"}, 64'(lat), 64'd3);
        check({name, "_data"}, n_out_data, r[31:0]);
        check({name, "_inexact"}, n_out_inexact, 1'b0);
        $display("narrow tag=%0d in=0x%02h signed=%0d data=0x%08h", t, d, s, n_out_data);
    endtask

    // Holds the operand until accepted; the handshake is judged on in_ready sampled mid-cycle.
    task automatic push_op(input logic [31:0] d, input logic s, input logic [3:0] t);
        logic acc;
        int   guard_cnt;
        in_valid = 1'b1; in_data = d; in_signed = s; in_tag = t;
        guard_cnt = 0;
        acc = 1'b0;
        while (!acc && guard_cnt < 50) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #1;
            guard_cnt++;
        end
        check("push_accepted", acc, 1'b1);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int          base;
        int          valid_cnt;
        logic [31:0] d;
        rst_n = 1'b0;
        in_valid = 1'b0; in_data = '0; in_signed = 1'b0; in_tag = '0; out_ready = 1'b1;
        n_in_valid = 1'b0; n_in_data = '0; n_in_signed = 1'b0; n_in_tag = '0; n_out_ready = 1'b1;

        #12;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_out_inexact", out_inexact, 1'b0);
        check("rst_out_tag", out_tag, 4'd0);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_n_out_valid", n_out_valid, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        send_check(32'd5,          1'b1, 4'd1, 32'h40A00000, 1'b0, "s_pos5");
        send_check(32'hFFFFFFFF,   1'b1, 4'd2, 32'hBF800000, 1'b0, "s_neg1");
        send_check(32'h80000000,   1'b1, 4'd3, 32'hCF000000, 1'b0, "s_most_neg");
        send_check(32'd0,          1'b1, 4'd4, 32'h00000000, 1'b0, "s_zero");
        send_check(32'd0,          1'b0, 4'd5, 32'h00000000, 1'b0, "u_zero");
        send_check(32'hFFFFFFFF,   1'b0, 4'd6, 32'h4F800000, 1'b1, "u_max");
        send_check(32'd16777217,   1'b0, 4'd7, 32'h4B800000, 1'b1, "u_tie_even");
        send_check(32'd16777219,   1'b0, 4'd8, 32'h4B800002, 1'b1, "u_tie_up");

        // Backpressure: six back-to-back operands, consumer stalls 5 cycles on the first result.
        repeat (5) @(posedge clk);
        base = rx_tags.size();
        fork
            begin
                @(posedge clk); #1;
                for (int t = 1; t <= 6; t++) push_op($urandom, 1'($urandom_range(0, 1)), 4'(t));
                in_valid = 1'b0;
            end
            begin
                int          waitc;
                logic [31:0] held;
                waitc = 0;
                while (!out_valid && waitc < 20) begin
                    @(posedge clk); #1;
                    waitc++;
                end
                check("bp_first_result", out_valid, 1'b1);
                out_ready = 1'b0;
                held = out_data;
                repeat (5) begin
                    @(negedge clk);
                    check("bp_in_ready_low", in_ready, 1'b0);
                    check("bp_data_held", out_data, held);
                end
                @(posedge clk); #1;
                out_ready = 1'b1;
                @(negedge clk);
                check("bp_in_ready_back", in_ready, 1'b1);
            end
        join
        repeat (10) @(posedge clk);
        check("bp_count", 64'(rx_tags.size() - base), 64'd6);
        if (rx_tags.size() - base == 6) begin
            for (int i = 0; i < 6; i++) check("bp_tag_order", rx_tags[base + i], 4'(i + 1));
        end

        // Full throughput: 100 random operands, no stalls.
        base = rx_tags.size();
        valid_cnt = 0;
        @(posedge clk); #1;
        for (int k = 0; k < 104; k++) begin
            if (k < 100) begin
                case ($urandom_range(0, 9))
                    0:       d = 32'd0;
                    1:       d = 32'h80000000;
                    2:       d = 32'hFFFFFFFF;
                    default: d = $urandom >> $urandom_range(0, 31);
                endcase
                in_valid = 1'b1; in_data = d;
                in_signed = 1'($urandom_range(0, 1)); in_tag = 4'(k);
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk); #1;
            if (out_valid) valid_cnt++;
        end
        repeat (3) @(posedge clk);
        check("thru_valid_cycles", 64'(valid_cnt), 64'd100);
        check("thru_count", 64'(rx_tags.size() - base), 64'd100);

        // Reset while three operands are in flight.
        base = rx_tags.size();
        @(posedge clk); #1;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1; in_data = $urandom; in_signed = 1'b1; in_tag = 4'(9 + k);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check("rstmid_pre_valid", out_valid, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("rstmid_out_valid", out_valid, 1'b0);
        check("rstmid_out_data", out_data, 32'd0);
        check("rstmid_out_inexact", out_inexact, 1'b0);
        check("rstmid_out_tag", out_tag, 4'd0);
        check("rstmid_in_ready", in_ready, 1'b1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("rstmid_no_ghosts", 64'(rx_tags.size() - base), 64'd0);

        // Narrow instance.
        send8(8'h80, 1'b1, 4'd1, "n_most_neg");
        check("n_most_neg_const", n_out_data, 32'hC3000000);
        send8(8'hFF, 1'b0, 4'd2, "n_u255");
        check("n_u255_const", n_out_data, 32'h437F0000);
        send8(8'hFF, 1'b1, 4'd3, "n_neg1");
        send8(8'h00, 1'b1, 4'd4, "n_zero");
        for (int k = 0; k < 8; k++) send8(8'($urandom), 1'($urandom_range(0, 1)), 4'(k), "n_rand");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/int_to_float_pipe.md
# int_to_float_pipe

Pipelined, parametrised integer-to-IEEE-754 single-precision converter for the logarithmic ALU datapath. It accepts signed or unsigned integers of width `INT_W` under a valid/ready handshake. It produces correctly rounded (round-to-nearest-even) binary32 results in a fixed three-stage pipeline, with an inexact flag and a passthrough tag. It replaces the combinational converter on paths that need two's-complement handling, wider inputs, rounding and backpressure.

## Interface
- `INT_W`, default 32: integer input width, legal range 2..64.
- `TAG_W`, default 4: width of the sideband tag carried alongside each operand, legal range 1..16.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `in_valid` input 1: the operand on `in_data` is offered.
- `in_ready` output 1: the converter accepts the operand this cycle.
- `in_data` input `INT_W`: integer operand.
- `in_signed` input 1: 1 means `in_data` is two's complement; 0 means unsigned.
- `in_tag` input `TAG_W`: sideband tag, returned unchanged with the result.
- `out_valid` output 1: the result is presented.
- `out_ready` input 1: the consumer accepts the result.
- `out_data` output 32: binary32 result.
- `out_inexact` output 1: the result was rounded (nonzero bits were discarded).
- `out_tag` output `TAG_W`: tag of the operand that produced the result.

## Operation
- **Stage 1 (S1), magnitude**
  - sign = `in_signed & in_data[INT_W-1]`.
  - mag = sign ? (~in_data + 1) : in_data, computed at `INT_W` bits, unsigned.
  - The most negative signed value yields mag = 2^(INT_W-1) with no overflow.
- **Stage 2 (S2), normalise**
  - Leading-one position p = index of the highest set bit of mag.
  - Left-shift mag so bit p lands at the MSB of an `INT_W`-bit normalised vector.
  - Record p and zero = (mag == 0).
- **Stage 3 (S3), round and pack**
  - Keep the 24 MSBs of the normalised vector (hidden bit + 23 fraction bits).
  - If `INT_W` > 24: guard = next bit, sticky = OR of the remaining bits.
  - Round up iff guard & (sticky | kept LSB).
  - If rounding carries out of 24 bits: mantissa becomes 1.000…, p increments by 1.
  - exponent = p + 127. Maximum is 64 + 127 = 191, so no overflow or infinity case exists.
  - `out_inexact` = guard | sticky.
  - If `INT_W` <= 24: no rounding; zero-pad the LSBs; `out_inexact` = 0.
- **Zero**: `out_data` = 0x00000000 (positive zero), `out_inexact` = 0, for both signed and unsigned modes.
- **Sign bit**: `out_data[31]` = sign from S1. An unsigned operand is never negative.
- **Flow control** (single global stall)
  - stall = `out_valid & ~out_ready`.
  - `in_ready` = ~stall.
  - When not stalled, every stage register loads from the previous stage, and each stage valid bit shifts forward.
  - When stalled, all stages hold.
  - Bubbles are not compressed.
- **Transfers**: an input transfer occurs when `in_valid & in_ready`; an output transfer occurs when `out_valid & out_ready`. Results leave in acceptance order, with the tag intact.
- **Simultaneous events**: an input and an output transfer in the same cycle are legal, giving full throughput of one conversion per cycle.
- **Reset**: asynchronous assertion clears all stage valid bits and all data registers immediately, mid-operation included. In-flight operands are discarded and never emitted.

## Timing
- Latency: 3 cycles from the input-transfer edge to `out_valid` high, with no stall.
- Throughput: 1 result per cycle while `out_ready` = 1.
- Reset values: `out_valid` = 0, `out_data` = 0x00000000, `out_inexact` = 0, `out_tag` = 0. `in_ready` = 1 during and after reset, because it is derived from `out_valid` = 0.
- Output stability: while `out_valid & ~out_ready`, `out_data`, `out_inexact` and `out_tag` stay constant.
- Combinational paths: `in_ready` depends combinationally on `out_ready`. No other combinational input-to-output path exists.

## Test plan
- **Signed basics**, `INT_W`=32, signed mode:
  - 5 -> 0x40A00000.
  - -1 -> 0xBF800000.
  - 0x80000000 -> 0xCF000000.
  - 0 -> 0x00000000.
  - All with `out_inexact` = 0 and latency 3.
- **Unsigned rounding**:
  - 0xFFFFFFFF -> 0x4F800000, inexact = 1.
  - 16777217 -> 0x4B800000 (tie, rounds to even), inexact = 1.
  - 16777219 -> 0x4B800002 (tie, rounds up), inexact = 1.
- **Backpressure**:
  - Stimulus: stream tags 1..6 back-to-back, with `out_ready` low for 5 cycles after the first result.
  - Required: `in_ready` low exactly while stalled, no loss or duplication, results in tag order 1..6, `out_data` held stable.
- **Full throughput**: 100 random operands with `in_valid` and `out_ready` held high -> one result per cycle, every result matching the reference model (integer to float with RNE).
- **Reset mid-flight**: pulse `rst_n` low while 3 operands are in the pipeline -> `out_valid` falls immediately, all outputs are zero, and none of those 3 results ever appears after release.
- **Narrow instance**, `INT_W`=8:
  - Signed -128 -> 0xC3000000.
  - Unsigned 255 -> 0x437F0000.
  - `out_inexact` always 0.
